// File: rtl/mux_lab_pkg.sv
// Shared types and helpers for the mux select sequencer.
package mux_lab_pkg;

  localparam int unsigned DefaultN    = 8;
  localparam int unsigned DefaultSelW = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Select index at which each word starts.
  function automatic int unsigned first_index(input bit msb_first,
                                              input int unsigned n = DefaultN);
    return msb_first ? n - 1 : 32'd0;
  endfunction

  // Select index of the final bit of each word.
  function automatic int unsigned last_index(input bit msb_first,
                                             input int unsigned n = DefaultN);
    return msb_first ? 32'd0 : n - 1;
  endfunction

endpackage

// File: rtl/sel_index_counter.sv
// Up/down select counter with load-to-first, enable and an at-last flag.
module sel_index_counter
  import mux_lab_pkg::*;
#(
  parameter int unsigned N         = DefaultN,
  parameter int unsigned SEL_W     = DefaultSelW,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_first,
  input  logic             enable,
  output logic [SEL_W-1:0] sel,
  output logic             at_last
);

  localparam logic [SEL_W-1:0] FirstIdx = SEL_W'(first_index(MSB_FIRST, N));
  localparam logic [SEL_W-1:0] LastIdx  = SEL_W'(last_index(MSB_FIRST, N));

  logic [SEL_W-1:0] sel_q;

  // Reload wins over stepping; stepping stops at the last index so it never wraps by itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= FirstIdx;
    end else if (load_first) begin
      sel_q <= FirstIdx;
    end else if (enable && !at_last) begin
      sel_q <= MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
    end
  end

  assign sel     = sel_q;
  assign at_last = (sel_q == LastIdx);

endmodule

// File: rtl/mux_select_sequencer.sv
// Serialises words through an external N:1 mux by stepping its select, one bit per handshake.
// A one-word holding buffer lets the next word stream in with no idle cycle between words.
module mux_select_sequencer
  import mux_lab_pkg::*;
#(
  parameter int unsigned N         = DefaultN,
  parameter int unsigned SEL_W     = DefaultSelW,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [N-1:0]     mux_in,
  output logic [SEL_W-1:0] mux_select,
  input  logic             mux_out,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             last,
  output logic             busy
);

  state_e       state_q;
  logic [N-1:0] mux_in_q;
  logic [N-1:0] buf_q;
  logic         buf_full_q;

  logic accept;
  logic xfer;
  logic at_last;

  // Ready depends only on registered state, never on bit_ready.
  assign word_ready = !reset && !buf_full_q;
  assign accept     = word_valid && word_ready;
  assign bit_valid  = (state_q == StShift);
  assign xfer       = bit_valid && bit_ready;

  sel_index_counter #(
    .N         (N),
    .SEL_W     (SEL_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sel_index_counter (
    .clk        (clk),
    .reset      (reset),
    .load_first (xfer && at_last),
    .enable     (xfer),
    .sel        (mux_select),
    .at_last    (at_last)
  );

  // Word sequencing: load the mux word, park the next one in the buffer, chain at the final bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mux_in_q   <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mux_in_q <= word_in;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (xfer && at_last) begin
            if (buf_full_q) begin
              mux_in_q   <= buf_q;
              buf_full_q <= 1'b0;
            end else if (accept) begin
              // Buffer empty and a word arrives on the final bit: skip the buffer.
              mux_in_q <= word_in;
            end else begin
              state_q <= StIdle;
            end
          end else if (accept) begin
            buf_q      <= word_in;
            buf_full_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mux_in  = mux_in_q;
  assign bit_out = mux_out;
  assign last    = bit_valid && at_last;
  assign busy    = bit_valid || buf_full_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer with LSB-first and MSB-first instances.
module tb_mux_select_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_valid1;
  logic       bit_ready;

  logic       word_ready0, word_ready1;
  logic [7:0] mux_in0, mux_in1;
  logic [2:0] mux_select0, mux_select1;
  logic       mux_out0, mux_out1;
  logic       bit_out0, bit_out1;
  logic       bit_valid0, bit_valid1;
  logic       last0, last1;
  logic       busy0, busy1;

  int checks;
  int errors;

  // Behavioural 8:1 muxes closing the loop.
  assign mux_out0 = mux_in0[mux_select0];
  assign mux_out1 = mux_in1[mux_select1];

  mux_select_sequencer #(
    .N         (8),
    .SEL_W     (3),
    .MSB_FIRST (1'b0)
  ) dut0 (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready0),
    .mux_in     (mux_in0),
    .mux_select (mux_select0),
    .mux_out    (mux_out0),
    .bit_out    (bit_out0),
    .bit_valid  (bit_valid0),
    .bit_ready  (bit_ready),
    .last       (last0),
    .busy       (busy0)
  );

  mux_select_sequencer #(
    .N         (8),
    .SEL_W     (3),
    .MSB_FIRST (1'b1)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid1),
    .word_ready (word_ready1),
    .mux_in     (mux_in1),
    .mux_select (mux_select1),
    .mux_out    (mux_out1),
    .bit_out    (bit_out1),
    .bit_valid  (bit_valid1),
    .bit_ready  (bit_ready),
    .last       (last1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    word_in     = 8'h00;
    word_valid  = 1'b0;
    word_valid1 = 1'b0;
    bit_ready   = 1'b1;
    step();
    step();
    checks++;
    if (word_ready0 !== 1'b0) begin
      errors++; $display("FAIL reset_word_ready_low: got %b expected 0", word_ready0);
    end
    checks++;
    if (bit_valid0 !== 1'b0 || last0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b last=%b busy=%b expected 0 0 0",
               bit_valid0, last0, busy0);
    end
    checks++;
    if (mux_in0 !== 8'h00 || mux_select0 !== 3'd0) begin
      errors++;
      $display("FAIL reset_mux0: got mux_in=%h sel=%0d expected 00 0", mux_in0, mux_select0);
    end
    checks++;
    if (mux_select1 !== 3'd7 || bit_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mux1: got sel=%0d valid=%b expected 7 0", mux_select1, bit_valid1);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (word_ready0 !== 1'b1 || word_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b %b expected 1 1", word_ready0, word_ready1);
    end
  endtask

  task automatic test_single_word();
    logic exp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    word_in    = 8'b10101010;
    word_valid = 1'b1;
    bit_ready  = 1'b1;
    checks++;
    if (bit_valid0 !== 1'b0 || word_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_accept: got valid=%b ready=%b expected 0 1",
               bit_valid0, word_ready0);
    end
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bit_valid0 !== 1'b1 || mux_select0 !== 3'(i) || bit_out0 !== exp[i]
          || last0 !== (i == 7)) begin
        errors++;
        $display("FAIL single_bit%0d: got valid=%b sel=%0d bit=%b last=%b expected 1 %0d %b %b",
                 i, bit_valid0, mux_select0, bit_out0, last0, i, exp[i], (i == 7));
      end
      step();
    end
    checks++;
    if (bit_valid0 !== 1'b0 || busy0 !== 1'b0 || mux_select0 !== 3'd0) begin
      errors++;
      $display("FAIL single_idle: got valid=%b busy=%b sel=%0d expected 0 0 0",
               bit_valid0, busy0, mux_select0);
    end
  endtask

  task automatic test_back_to_back();
    logic exp [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    word_in    = 8'b10010011;
    word_valid = 1'b1;
    bit_ready  = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k == 0) word_in = 8'hFF;
      else word_valid = 1'b0;
      checks++;
      if (bit_valid0 !== 1'b1 || busy0 !== 1'b1 || bit_out0 !== exp[k]
          || mux_select0 !== 3'(k % 8) || last0 !== ((k % 8) == 7)) begin
        errors++;
        $display("FAIL b2b_bit%0d: got valid=%b busy=%b bit=%b sel=%0d last=%b expected 1 1 %b %0d %b",
                 k, bit_valid0, busy0, bit_out0, mux_select0, last0, exp[k], k % 8,
                 ((k % 8) == 7));
      end
      checks++;
      if (word_ready0 !== (k == 0 || k >= 8)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b expected %b", k, word_ready0, (k == 0 || k >= 8));
      end
      checks++;
      if (mux_in0 !== ((k < 8) ? 8'h93 : 8'hFF)) begin
        errors++;
        $display("FAIL b2b_mux_in%0d: got %h expected %h", k, mux_in0,
                 ((k < 8) ? 8'h93 : 8'hFF));
      end
      step();
    end
    checks++;
    if (bit_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got valid=%b busy=%b expected 0 0", bit_valid0, busy0);
    end
  endtask

  task automatic test_backpressure();
    word_in    = 8'b10010011;
    word_valid = 1'b1;
    bit_ready  = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (mux_select0 !== 3'd4 || bit_out0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_reach4: got sel=%0d bit=%b expected 4 1", mux_select0, bit_out0);
    end
    bit_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (mux_select0 !== 3'd4 || bit_out0 !== 1'b1 || bit_valid0 !== 1'b1
          || mux_in0 !== 8'h93) begin
        errors++;
        $display("FAIL bp_hold%0d: got sel=%0d bit=%b valid=%b mux_in=%h expected 4 1 1 93",
                 j, mux_select0, bit_out0, bit_valid0, mux_in0);
      end
    end
    bit_ready = 1'b1;
    step();
    checks++;
    if (mux_select0 !== 3'd5 || bit_out0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume5: got sel=%0d bit=%b expected 5 0", mux_select0, bit_out0);
    end
    step();
    step();
    checks++;
    if (mux_select0 !== 3'd7 || bit_out0 !== 1'b1 || last0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_last: got sel=%0d bit=%b last=%b expected 7 1 1",
               mux_select0, bit_out0, last0);
    end
    step();
    checks++;
    if (bit_valid0 !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got valid=%b expected 0", bit_valid0);
    end
  endtask

  task automatic test_msb_first();
    word_in     = 8'b00000001;
    word_valid1 = 1'b1;
    bit_ready   = 1'b1;
    step();
    word_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bit_valid1 !== 1'b1 || mux_select1 !== 3'(7 - i) || bit_out1 !== (i == 7)
          || last1 !== (i == 7)) begin
        errors++;
        $display("FAIL msb_bit%0d: got valid=%b sel=%0d bit=%b last=%b expected 1 %0d %b %b",
                 i, bit_valid1, mux_select1, bit_out1, last1, 7 - i, (i == 7), (i == 7));
      end
      step();
    end
    checks++;
    if (bit_valid1 !== 1'b0 || mux_select1 !== 3'd7) begin
      errors++;
      $display("FAIL msb_idle: got valid=%b sel=%0d expected 0 7", bit_valid1, mux_select1);
    end
  endtask

  task automatic test_reset_midstream();
    word_in    = 8'b10010011;
    word_valid = 1'b1;
    bit_ready  = 1'b1;
    step();
    word_in = 8'hFF;
    step();
    word_valid = 1'b0;
    step();
    step();
    checks++;
    if (mux_select0 !== 3'd3 || word_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_setup: got sel=%0d ready=%b expected 3 0", mux_select0, word_ready0);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bit_valid0 !== 1'b0 || mux_in0 !== 8'h00 || mux_select0 !== 3'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%b mux_in=%h sel=%0d busy=%b expected 0 00 0 0",
               bit_valid0, mux_in0, mux_select0, busy0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (word_ready0 !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b expected 1", word_ready0);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bit_valid0 !== 1'b0 || mux_in0 !== 8'h00) begin
        errors++;
        $display("FAIL midrst_discard%0d: got valid=%b mux_in=%h expected 0 00",
                 i, bit_valid0, mux_in0);
      end
    end
  endtask

  task automatic test_valid_during_reset();
    logic exp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    reset      = 1'b1;
    word_in    = 8'h5A;
    word_valid = 1'b1;
    bit_ready  = 1'b1;
    #1;
    checks++;
    if (word_ready0 !== 1'b0) begin
      errors++; $display("FAIL rstvalid_ready: got %b expected 0", word_ready0);
    end
    step();
    checks++;
    if (bit_valid0 !== 1'b0 || mux_in0 !== 8'h00) begin
      errors++;
      $display("FAIL rstvalid_not_taken: got valid=%b mux_in=%h expected 0 00",
               bit_valid0, mux_in0);
    end
    reset = 1'b0;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bit_valid0 !== 1'b1 || mux_select0 !== 3'(i) || bit_out0 !== exp[i]) begin
        errors++;
        $display("FAIL rstvalid_bit%0d: got valid=%b sel=%0d bit=%b expected 1 %0d %b",
                 i, bit_valid0, mux_select0, bit_out0, i, exp[i]);
      end
      step();
    end
    checks++;
    if (bit_valid0 !== 1'b0) begin
      errors++; $display("FAIL rstvalid_idle: got valid=%b expected 0", bit_valid0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_reset_midstream();
    test_valid_during_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
Upstream stage of the 8:1 multiplexer. Accepts 8-bit words over a valid/ready handshake and presents each word on the mux data input. Steps the mux select through all N indices, one bit per handshake, and forwards the returned mux output as a serial bit stream. A one-word holding buffer lets the next word be accepted while the current one is being shifted, so consecutive words stream with no bubble.

Parameters:
N, 8, mux data width and number of bits per word; must be a power of 2.
SEL_W, 3, select width; must equal log2(N).
MSB_FIRST, 0, 0: select steps 0..N-1; 1: select steps N-1..0.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous reset, active-high.
word_in  input  N  parallel word to serialise.
word_valid  input  1  word_in is valid.
word_ready  output  1  block can accept a word this cycle.
mux_in  output  N  word driven to the mux data input.
mux_select  output  SEL_W  driven to the mux select input.
mux_out  input  1  mux output fed back; combinational function of mux_in and mux_select.
bit_out  output  1  serial bit; combinationally equal to mux_out.
bit_valid  output  1  bit_out is valid.
bit_ready  input  1  downstream accepts bit_out.
last  output  1  high with bit_valid on the final bit of a word.
busy  output  1  high while in SHIFT or while the buffer is full.

Behaviour:
- Reset, sampled on clk edge while reset=1:
  - state=IDLE, mux_in=0, mux_select=first index (0, or N-1 if MSB_FIRST), bit_valid=0, last=0, buffer empty, busy=0.
  - word_ready is forced 0 while reset=1.
- word_ready = !reset && buffer empty. It depends only on registered state, with no combinational path from bit_ready.
- Accept happens when word_valid && word_ready.
  - In IDLE, an accepted word loads mux_in directly on the next edge. The buffer stays empty.
  - In SHIFT, the word goes into the buffer.
- States:
  - IDLE: bit_valid=0. On accept, next cycle enters SHIFT with mux_in=word_in, mux_select=first index, bit_valid=1. Latency from accept to first bit_valid is 1 cycle.
  - SHIFT: bit_valid=1. A transfer occurs when bit_valid && bit_ready; each transfer advances mux_select by +1 (or -1 if MSB_FIRST).
- Backpressure: bit_ready=0 holds mux_select, mux_in and bit_valid unchanged.
- last = bit_valid && (mux_select == final index).
- On a transfer at the final index:
  - Buffer full: mux_in loads the buffer, mux_select returns to the first index, state stays SHIFT, buffer becomes empty. No idle cycle.
  - Buffer empty: go to IDLE, bit_valid=0.
- Simultaneous final transfer and accept with buffer empty: the incoming word loads mux_in directly and state stays SHIFT.
- The select counter wraps only via explicit reload at the final index. It is never incremented past N-1 or decremented below 0.
- Reset mid-operation:
  - The in-flight word and the buffered word are discarded.
  - The outputs take their reset values on the next edge.
  - No partial bit is reported after reset.

Decomposition:
- Shared package mux_lab_pkg:
  - state encoding (IDLE=0, SHIFT=1)
  - default N/SEL_W constants
  - function first_index(MSB_FIRST) and last_index(MSB_FIRST)
- One natural sub-module: sel_index_counter. SEL_W-bit up/down counter with load-first and enable; it emits an at_last flag.

Test Plan:
1. MSB_FIRST=0; word 8'b10101010, bit_ready=1.
   -> first bit_valid 1 cycle after accept; mux_select 0..7 on 8 consecutive cycles; bit_out 0,1,0,1,0,1,0,1; last only at select=7; then IDLE.
2. Back-to-back words 8'b10010011 then 8'hFF, word_valid held.
   -> second word buffered (word_ready=0 until it is consumed); 16 consecutive bit_valid cycles with no bubble; bits 1,1,0,0,1,0,0,1 then eight 1s.
3. Word 8'b10010011; bit_ready=0 for 3 cycles while mux_select=4.
   -> mux_select holds at 4; bit_out holds at 1; stream resumes at select 5 after bit_ready returns.
4. MSB_FIRST=1; word 8'b00000001.
   -> mux_select 7..0; bit_out seven 0s then 1; last at select=0.
5. Reset asserted for 1 cycle at select=3 with the buffer full.
   -> next cycle bit_valid=0, mux_in=0, select=0, word_ready=1; the discarded word never appears.
6. word_valid asserted during reset.
   -> word_ready=0 and the word is not accepted; the same word, re-presented after reset, streams normally.
